spi_print_tx: RTL
=================

Name: spi_print_tx

Overview:
- Byte-wide debug print transmitter inside the user project.
- Serialises bytes written by the core's MMIO print register onto two user GPIOs: spi_clk drives mprj_io[4] and spi_mosi drives mprj_io[1].
- The existing testbench SPI monitor assembles each byte MSB first on rising spi_clk, counts 8 bits per byte with no framing, and prints the characters.
- Contains a small byte FIFO so the core rarely stalls, and a clock-divided shift engine.

Parameters:
- DEPTH, 4: FIFO depth in bytes; must be a power of two and at least 2.
- CLK_DIV, 2: spi_clk half-period in clk cycles; must be at least 1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte write request.
- in_data  in  8  byte to transmit.
- in_ready  out  1  FIFO can accept a byte.
- flush  in  1  synchronous discard of queued (not in-flight) bytes.
- busy  out  1  FIFO non-empty or shifter active.
- spi_clk  out  1  serial clock; idles low.
- spi_mosi  out  1  serial data, MSB first.
- spi_oe  out  1  GPIO output enable; constant 1 after reset.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - spi_clk=0, spi_mosi=0, spi_oe=0; spi_oe becomes 1 on the first clk edge after rst_n deasserts.
  - busy=0, in_ready=1 (it is combinational from the registered count).
  - FIFO empty, state IDLE.
- FIFO:
  - Write occurs when in_valid && in_ready.
  - in_ready = (count != DEPTH). It does not look ahead to a same-cycle pop.
  - Pointers are log2(DEPTH) bits wide and wrap naturally; count is log2(DEPTH)+1 bits.
  - A simultaneous push and pop leaves count unchanged.
- State machine:
  - IDLE: if count != 0, pop the head into the shift register and go to LOAD.
  - LOAD: spi_mosi <= shreg[7]; bitcnt <= 0; divcnt <= 0; go to LOW.
  - LOW: spi_clk stays 0. When divcnt == CLK_DIV-1: spi_clk <= 1, divcnt <= 0, go to HIGH. Otherwise increment divcnt.
  - HIGH: spi_clk stays 1. When divcnt == CLK_DIV-1: spi_clk <= 0, divcnt <= 0, then:
    - if bitcnt == 7: pop the next byte directly and go to LOAD if count != 0, otherwise go to IDLE;
    - else: shreg <= shreg<<1, spi_mosi <= shreg[6], bitcnt++, go to LOW.
- Timing:
  - spi_mosi changes only on the clk edge that drops spi_clk (or in LOAD), giving CLK_DIV cycles of setup and hold around each rising edge.
  - One byte occupies 1 + 16*CLK_DIV clk cycles.
  - Back-to-back bytes are separated only by the LOAD cycle.
  - Latency: for a write at edge E into an idle empty block, the pop happens at E+1, LOAD at E+2, and the first spi_clk rise is registered at edge E+2+CLK_DIV.
- spi_mosi holds its last bit while IDLE.
- busy = (count != 0) || (state != IDLE).
- flush:
  - Sets count and both pointers to 0 on the next edge.
  - The in-flight byte completes all 8 bits.
  - A write in the same cycle as flush is dropped; in_ready stays 1.
- Reset mid-byte: outputs return to reset values immediately and asynchronously. The partial byte is lost; the receiver must be reset with the chip.
- No framing: the receiver depends on an exact count of 8 rising edges per byte. spi_clk must never glitch or emit extra rising edges.

Optional Feature:
- Macro: SPI_PRINT_CS_EN.
- Defined: adds output port spi_cs_n (1 bit, reset 1).
  - Goes low in the LOAD cycle and stays low through all 8 bits.
  - Goes high on the edge that leaves HIGH with bitcnt == 7, for one cycle minimum even when another byte follows. The back-to-back gap grows to 2 cycles (an extra deselect cycle precedes LOAD).
- Undefined: no spi_cs_n port and 1-cycle gap, as described above.

Decomposition:
- Package spi_print_pkg holds:
  - typedef state_t {IDLE, LOAD, LOW, HIGH};
  - localparam BYTE_BITS = 8.
- One sub-module, spi_print_fifo: a parameterised synchronous byte FIFO with push, pop, flush, count, full and empty, using the same async active-low reset.
- The shift engine lives in the top module.

Test Plan:
1. Reset and idle: with CLK_DIV=2, release rst_n and wait 20 cycles. Expect spi_clk=0, in_ready=1, busy=0, spi_oe=1 and no spi_clk rise.
2. Single byte: write 0x48. Expect exactly 8 rises with spi_mosi 0,1,0,0,1,0,0,0 at the rises. The first rise is at write edge+4, the rise period is 4 cycles, busy drops 33 cycles after the pop, and the monitor prints "H".
3. Burst with backpressure: with DEPTH=4, hold in_valid over "Hello\n". Expect 5 acceptances, then in_ready=0 until the first byte finishes. All six characters print in order, and the last rise of each byte is followed by the next byte's first rise 5 cycles later.
4. Flush: queue "ABC", then pulse flush during bit 3 of 'A'. Expect 'A' to complete (8 rises), then no further rises, busy=0 and count=0.
5. Reset mid-byte: assert rst_n low at bit 4 of 0x55. Expect spi_clk=0 and spi_mosi=0 in the same timestep and the FIFO empty. After release, writing 0x5A produces exactly 0x5A.
6. With SPI_PRINT_CS_EN defined, send two back-to-back bytes. Expect spi_cs_n low across each byte's 8 rises and high for exactly 1 cycle between the bytes.

Source files
------------

// File: rtl/spi_print_pkg.sv
// Shared types and constants for the SPI debug print transmitter.
package spi_print_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH
    } state_t;

    localparam int BYTE_BITS = 8;

endpackage

// File: rtl/spi_print_fifo.sv
// Small synchronous byte FIFO feeding the print shifter; flush discards all queued entries.
module spi_print_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_print_tx.sv
// Byte-wide debug print transmitter: FIFO plus clock-divided MSB-first shifter on spi_clk/spi_mosi.
// Define SPI_PRINT_CS_EN to add an active-low chip select with a one-cycle deselect between bytes.
module spi_print_tx
    import spi_print_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       flush,
    output logic       busy,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       spi_oe
`ifdef SPI_PRINT_CS_EN
    ,
    output logic       spi_cs_n
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(BYTE_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_BITS - 1);

    state_t               state_q, state_d;
    logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0]     divcnt_q, divcnt_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 oe_q;
    logic [BYTE_BITS-1:0] shreg_q;
    logic                 load_sh;
    logic                 shift_sh;

    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           head;
    logic                 pop;
    logic                 avail;

`ifdef SPI_PRINT_CS_EN
    logic                 cs_q, cs_d;
    assign spi_cs_n = cs_q;
`endif

    spi_print_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .flush     (flush),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready = !fifo_full;
    // A byte arriving at a boundary during flush counts as discarded, not started.
    assign avail    = !fifo_empty && !flush;
    assign busy     = !fifo_empty || (state_q != IDLE);
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_oe   = oe_q;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        divcnt_d = divcnt_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        pop      = 1'b0;
        load_sh  = 1'b0;
        shift_sh = 1'b0;
`ifdef SPI_PRINT_CS_EN
        cs_d     = cs_q;
`endif
        case (state_q)
            IDLE: begin
                if (avail) begin
                    pop     = 1'b1;
                    load_sh = 1'b1;
                    state_d = LOAD;
`ifdef SPI_PRINT_CS_EN
                    cs_d    = 1'b0;
`endif
                end
            end
            LOAD: begin
                mosi_d   = shreg_q[BYTE_BITS-1];
                bitcnt_d = '0;
                divcnt_d = '0;
                state_d  = LOW;
            end
            LOW: begin
                if (divcnt_q == DIV_LAST) begin
                    sclk_d   = 1'b1;
                    divcnt_d = '0;
                    state_d  = HIGH;
                end else begin
                    divcnt_d = divcnt_q + DIV_W'(1);
                end
            end
            HIGH: begin
                if (divcnt_q == DIV_LAST) begin
                    sclk_d   = 1'b0;
                    divcnt_d = '0;
                    if (bitcnt_q == BIT_LAST) begin
`ifdef SPI_PRINT_CS_EN
                        // Always pass through IDLE so chip select is seen high between bytes.
                        cs_d    = 1'b1;
                        state_d = IDLE;
`else
                        if (avail) begin
                            pop     = 1'b1;
                            load_sh = 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
`endif
                    end else begin
                        shift_sh = 1'b1;
                        mosi_d   = shreg_q[BYTE_BITS-2];
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                        state_d  = LOW;
                    end
                end else begin
                    divcnt_d = divcnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            oe_q     <= 1'b0;
`ifdef SPI_PRINT_CS_EN
            cs_q     <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            divcnt_q <= divcnt_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            oe_q     <= 1'b1;
`ifdef SPI_PRINT_CS_EN
            cs_q     <= cs_d;
`endif
        end
    end

    // Shift data is only meaningful between LOAD and the last HIGH, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_sh)       shreg_q <= head;
        else if (shift_sh) shreg_q <= {shreg_q[BYTE_BITS-2:0], 1'b0};
    end

endmodule
